// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants used by the instruction aligner.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DRAIN = 3'd4
    } align_state_t;

    // Low two bits of a halfword that mark the start of a 32-bit instruction.
    localparam logic [1:0]  RVC_FULL  = 2'b11;

    // PC advance for a compressed and a full-width instruction.
    localparam logic [31:0] PC_STEP_C = 32'd2;
    localparam logic [31:0] PC_STEP_F = 32'd4;

    // Masks for word alignment of fetch addresses and halfword alignment of redirects.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] HALF_MASK = 32'hFFFF_FFFE;

    // True when a halfword with these low bits begins a 32-bit instruction.
    function automatic logic is_full_start(input logic [1:0] lo_bits);
        return (lo_bits == RVC_FULL);
    endfunction

endpackage

// File: rtl/instr_align_if.sv
// Fetch request/response and instruction output handshakes of the aligner.
// master: the aligner side; slave: the cache plus downstream consumer side.
interface instr_align_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_c;
    logic        out_ready;

    modport master (
        output req_valid, req_addr,
        input  req_ready,
        input  resp_valid, resp_data,
        output out_valid, out_instr, out_pc, out_is_c,
        input  out_ready
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready,
        output resp_valid, resp_data,
        input  out_valid, out_instr, out_pc, out_is_c,
        output out_ready
    );

endinterface

// File: rtl/instr_align.sv
// Fetch-side instruction aligner: walks the PC in halfword steps, issues
// word-aligned fetches, stitches instructions straddling a word boundary,
// keeps the spare upper halfword of each word and emits one raw instruction
// (compressed ones zero-extended) per output handshake.
module instr_align
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    input  logic [31:0]   flush_pc,
    instr_align_if.master bus
);

    align_state_t state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic [15:0]  hold_r, hold_s;
    logic         hold_valid_r, hold_valid_s;
    logic         req_valid_r, req_valid_s;
    logic [31:0]  req_addr_r, req_addr_s;
    logic         out_valid_r, out_valid_s;
    logic [31:0]  out_instr_r, out_instr_s;
    logic [31:0]  out_pc_r, out_pc_s;
    logic         out_is_c_r, out_is_c_s;

    logic [31:0]  pc_plus_c_s;
    logic [31:0]  pc_plus_f_s;
    logic         hold_serves_c_s;

    assign pc_plus_c_s     = pc_r + PC_STEP_C;
    assign pc_plus_f_s     = pc_r + PC_STEP_F;
    // The halfword at pc is already buffered and is a complete compressed instruction.
    assign hold_serves_c_s = pc_r[1] && hold_valid_r && !is_full_start(hold_r[1:0]);

    // Next-state and next-register computation for the whole aligner.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        req_valid_s  = req_valid_r;
        req_addr_s   = req_addr_r;
        out_valid_s  = out_valid_r;
        out_instr_s  = out_instr_r;
        out_pc_s     = out_pc_r;
        out_is_c_s   = out_is_c_r;

        if (rdy_in) begin
            case (state_r)
                IDLE: begin
                    if (hold_serves_c_s) begin
                        out_valid_s  = 1'b1;
                        out_instr_s  = {16'h0000, hold_r};
                        out_pc_s     = pc_r;
                        out_is_c_s   = 1'b1;
                        pc_s         = pc_plus_c_s;
                        hold_valid_s = 1'b0;
                        state_s      = OUT;
                    end else begin
                        req_valid_s = 1'b1;
                        // With the lower half of a full instruction buffered, fetch the next word.
                        if (pc_r[1] && hold_valid_r) begin
                            req_addr_s = pc_plus_c_s & WORD_MASK;
                        end else begin
                            req_addr_s = pc_r & WORD_MASK;
                        end
                        state_s = REQ;
                    end
                end

                REQ: begin
                    if (bus.req_ready) begin
                        req_valid_s = 1'b0;
                        state_s     = WAIT;
                    end else begin
                        state_s = REQ;
                    end
                end

                WAIT: begin
                    if (bus.resp_valid) begin
                        if (!pc_r[1]) begin
                            out_pc_s = pc_r;
                            if (is_full_start(bus.resp_data[1:0])) begin
                                out_valid_s  = 1'b1;
                                out_instr_s  = bus.resp_data;
                                out_is_c_s   = 1'b0;
                                pc_s         = pc_plus_f_s;
                                hold_valid_s = 1'b0;
                                state_s      = OUT;
                            end else begin
                                out_valid_s  = 1'b1;
                                out_instr_s  = {16'h0000, bus.resp_data[15:0]};
                                out_is_c_s   = 1'b1;
                                hold_s       = bus.resp_data[31:16];
                                hold_valid_s = 1'b1;
                                pc_s         = pc_plus_c_s;
                                state_s      = OUT;
                            end
                        end else if (hold_valid_r) begin
                            // Straddle: buffered lower half plus low half of the new word.
                            out_valid_s  = 1'b1;
                            out_instr_s  = {bus.resp_data[15:0], hold_r};
                            out_pc_s     = pc_r;
                            out_is_c_s   = 1'b0;
                            hold_s       = bus.resp_data[31:16];
                            hold_valid_s = 1'b1;
                            pc_s         = pc_plus_f_s;
                            state_s      = OUT;
                        end else begin
                            // Refill: only the upper halfword belongs to the stream.
                            hold_s       = bus.resp_data[31:16];
                            hold_valid_s = 1'b1;
                            state_s      = IDLE;
                        end
                    end else begin
                        state_s = WAIT;
                    end
                end

                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_s = 1'b0;
                        state_s     = IDLE;
                    end else begin
                        state_s = OUT;
                    end
                end

                DRAIN: begin
                    // The response of the request issued before the redirect is stale.
                    if (bus.resp_valid) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DRAIN;
                    end
                end

                default: begin
                    state_s      = IDLE;
                    hold_valid_s = 1'b0;
                    req_valid_s  = 1'b0;
                    out_valid_s  = 1'b0;
                end
            endcase

            // Redirect overrides whatever the state machine decided above.
            if (flush_in) begin
                pc_s = flush_pc & HALF_MASK;
                if (state_r == DRAIN) begin
                    state_s = state_s;
                end else begin
                    hold_valid_s = 1'b0;
                    out_valid_s  = 1'b0;
                    req_valid_s  = 1'b0;
                    if (state_r == WAIT) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = IDLE;
                    end
                end
            end else begin
                pc_s = pc_s;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, PC, hold buffer and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            hold_r       <= 16'h0000;
            hold_valid_r <= 1'b0;
            req_valid_r  <= 1'b0;
            req_addr_r   <= 32'h0000_0000;
            out_valid_r  <= 1'b0;
            out_instr_r  <= 32'h0000_0000;
            out_pc_r     <= 32'h0000_0000;
            out_is_c_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            req_valid_r  <= req_valid_s;
            req_addr_r   <= req_addr_s;
            out_valid_r  <= out_valid_s;
            out_instr_r  <= out_instr_s;
            out_pc_r     <= out_pc_s;
            out_is_c_r   <= out_is_c_s;
        end
    end

    assign bus.req_valid = req_valid_r;
    assign bus.req_addr  = req_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_pc    = out_pc_r;
    assign bus.out_is_c  = out_is_c_r;

endmodule

// File: tb/tb_instr_align.sv
// Self-checking bench for instr_align: a cache responder with random latency,
// directed scenarios and a randomized stream checked against an ISA-level
// model that decodes the instruction sequence straight from memory.
`timescale 1ns/1ps
module tb_instr_align;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0200;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [31:0] flush_pc;

    int vecs = 0;
    int errs = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] req_log [$];
    logic [31:0] pend_addr;
    int          resp_cnt;
    int unsigned lat_min = 1;
    int unsigned lat_max = 3;
    bit          ready_en;
    bit          rdy_prev;

    instr_align_if bus();

    instr_align #(.RESET_PC(TB_RESET_PC)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .flush_in (flush),
        .flush_pc (flush_pc),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = get_word(a & 32'hFFFF_FFFC);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Decode the instruction at pc from memory and advance pc past it.
    task automatic model_next(inout logic [31:0] pc, output logic [31:0] instr, output logic is_c);
        logic [15:0] lo;
        lo = half_at(pc);
        if (lo[1:0] == 2'b11) begin
            instr = {half_at(pc + 32'd2), lo};
            is_c  = 1'b0;
            pc    = pc + 32'd4;
        end else begin
            instr = {16'h0000, lo};
            is_c  = 1'b1;
            pc    = pc + 32'd2;
        end
    endtask

    // Cache model: one outstanding request, response after lat_min..lat_max cycles.
    initial begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 32'h0;
        resp_cnt       = 0;
        rdy_prev       = 1'b1;
        pend_addr      = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                resp_cnt       = 0;
                bus.resp_valid = 1'b0;
            end else if (bus.resp_valid && !rdy_prev) begin
                bus.resp_valid = 1'b1;
            end else begin
                bus.resp_valid = 1'b0;
                if (resp_cnt > 0) begin
                    resp_cnt = resp_cnt - 1;
                    if (resp_cnt == 0) begin
                        bus.resp_valid = 1'b1;
                        bus.resp_data  = get_word(pend_addr);
                    end
                end
            end
            bus.req_ready = ready_en && ($urandom_range(0, 3) != 0);
            if (!rst && rdy && !flush && bus.req_valid && bus.req_ready) begin
                pend_addr = bus.req_addr;
                resp_cnt  = int'($urandom_range(lat_min, lat_max));
                req_log.push_back(bus.req_addr);
            end
            rdy_prev = rdy;
        end
    end

    // Wait for an output handshake; out_ready/rdy_in are randomized with the given percentages.
    task automatic wait_out(input int budget, input int unsigned ready_pct, input int unsigned rdy_pct, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            rdy           = ($urandom_range(0, 99) < rdy_pct);
            if (bus.out_valid === 1'b1 && bus.out_ready && rdy) got = 1'b1;
        end
    endtask

    task automatic wait_req(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.req_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_out_pending(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) got = 1'b1;
        end
    endtask

    // Quiesce the fetch bus, then redirect to target.
    task automatic flush_to(input logic [31:0] target, input bit keep_ready);
        bus.out_ready = 1'b0;
        ready_en      = 1'b0;
        rdy           = 1'b1;
        repeat (8) @(negedge clk);
        req_log.delete();
        flush    = 1'b1;
        flush_pc = target;
        @(negedge clk);
        flush    = 1'b0;
        ready_en = keep_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0;
        bus.out_ready = 1'b0; ready_en = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (bus.req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_is_c !== 1'b0 ||
            bus.req_addr !== 32'h0 || bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin
            errs++;
            $display("FAIL reset_state: req_v=%b out_v=%b is_c=%b addr=%h instr=%h pc=%h, required all zero",
                     bus.req_valid, bus.out_valid, bus.out_is_c, bus.req_addr, bus.out_instr, bus.out_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned_full;
        bit got;
        wait_req(10, got);
        vecs++;
        if (!got || bus.req_addr !== TB_RESET_PC) begin
            errs++; $display("FAIL first_req: got=%b addr=%h, required %h", got, bus.req_addr, TB_RESET_PC);
        end
        ready_en = 1'b1;
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== 32'h00A00093 || bus.out_pc !== TB_RESET_PC || bus.out_is_c !== 1'b0) begin
            errs++; $display("FAIL aligned_full: got=%b instr=%h pc=%h c=%b, required 00a00093 %h 0",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c, TB_RESET_PC);
        end
        wait_req(20, got);
        vecs++;
        if (!got || bus.req_addr !== TB_RESET_PC + 32'd4) begin
            errs++; $display("FAIL next_req: got=%b addr=%h, required %h", got, bus.req_addr, TB_RESET_PC + 32'd4);
        end
    endtask

    task automatic test_two_compressed;
        bit got;
        flush_to(32'h0000_0300, 1'b1);
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== 32'h00004505 || bus.out_pc !== 32'h300 || bus.out_is_c !== 1'b1) begin
            errs++; $display("FAIL c_first: got=%b instr=%h pc=%h c=%b, required 00004505 300 1",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c);
        end
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== 32'h00004585 || bus.out_pc !== 32'h302 || bus.out_is_c !== 1'b1) begin
            errs++; $display("FAIL c_from_hold: got=%b instr=%h pc=%h c=%b, required 00004585 302 1",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c);
        end
        vecs++;
        if (req_log.size() != 1 || req_log[0] !== 32'h300) begin
            errs++; $display("FAIL c_no_refetch: %0d requests, required exactly one to 300", req_log.size());
        end
    endtask

    task automatic test_straddle;
        bit got;
        flush_to(32'h0000_0403, 1'b1);
        wait_out(80, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== 32'h00A00093 || bus.out_pc !== 32'h402 || bus.out_is_c !== 1'b0) begin
            errs++; $display("FAIL straddle: got=%b instr=%h pc=%h c=%b, required 00a00093 402 0",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c);
        end
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== 32'h00004501 || bus.out_pc !== 32'h406 || bus.out_is_c !== 1'b1) begin
            errs++; $display("FAIL straddle_hold: got=%b instr=%h pc=%h c=%b, required 00004501 406 1",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c);
        end
        vecs++;
        if (req_log.size() != 2 || req_log[0] !== 32'h400 || req_log[1] !== 32'h404) begin
            errs++; $display("FAIL straddle_reqs: %0d requests, required 400 then 404", req_log.size());
        end
    endtask

    task automatic test_flush_wait;
        bit          got;
        int          spurious;
        logic [31:0] mpc;
        logic [31:0] ei;
        logic        ec;
        flush_to(32'h0000_0500, 1'b0);
        lat_min  = 5; lat_max = 5;
        ready_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (req_log.size() == 1) got = 1'b1;
        end
        flush    = 1'b1;
        flush_pc = 32'h0000_0100;
        @(negedge clk);
        flush   = 1'b0;
        lat_min = 1; lat_max = 3;
        req_log.delete();
        spurious = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.out_valid !== 1'b0) spurious++;
            if (bus.req_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        vecs++;
        if (!got || bus.req_addr !== 32'h100 || spurious != 0) begin
            errs++; $display("FAIL flush_wait: got=%b addr=%h spurious=%0d, required addr 100 and none",
                             got, bus.req_addr, spurious);
        end
        mpc = 32'h100;
        model_next(mpc, ei, ec);
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== ei || bus.out_pc !== 32'h100 || bus.out_is_c !== ec) begin
            errs++; $display("FAIL flush_target: got=%b instr=%h pc=%h c=%b, required %h 100 %b",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c, ei, ec);
        end
    endtask

    task automatic test_backpressure;
        bit          got;
        int          n;
        logic [31:0] mpc;
        logic [31:0] ei;
        logic        ec;
        flush_to(32'h0000_0600, 1'b1);
        mpc = 32'h600;
        model_next(mpc, ei, ec);
        wait_out_pending(50, got);
        n = req_log.size();
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (!got || bus.out_valid !== 1'b1 || bus.out_instr !== ei || bus.out_pc !== 32'h600 ||
                bus.out_is_c !== ec || req_log.size() != n) begin
                errs++; $display("FAIL backpressure[%0d]: v=%b instr=%h pc=%h c=%b reqs=%0d, required 1 %h 600 %b %0d",
                                 i, bus.out_valid, bus.out_instr, bus.out_pc, bus.out_is_c, req_log.size(), ei, ec, n);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_freeze;
        bit          got;
        logic [31:0] mpc;
        logic [31:0] ei;
        logic        ec;
        flush_to(32'h0000_0700, 1'b0);
        wait_req(10, got);
        vecs++;
        if (!got || bus.req_addr !== 32'h700) begin
            errs++; $display("FAIL freeze_req: got=%b addr=%h, required 700", got, bus.req_addr);
        end
        rdy = 1'b0; ready_en = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0800;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h700 || req_log.size() != 0) begin
                errs++; $display("FAIL freeze[%0d]: v=%b addr=%h reqs=%0d, required 1 700 0",
                                 i, bus.req_valid, bus.req_addr, req_log.size());
            end
        end
        flush = 1'b0; rdy = 1'b1;
        mpc = 32'h700;
        model_next(mpc, ei, ec);
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== ei || bus.out_pc !== 32'h700 || bus.out_is_c !== ec) begin
            errs++; $display("FAIL freeze_resume: got=%b instr=%h pc=%h c=%b, required %h 700 %b",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c, ei, ec);
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        flush_to(32'h0000_0900, 1'b1);
        wait_out_pending(50, got);
        rst = 1'b1;
        #1;
        vecs++;
        if (!got || bus.out_valid !== 1'b0 || bus.req_valid !== 1'b0 || bus.out_instr !== 32'h0 ||
            bus.out_pc !== 32'h0 || bus.out_is_c !== 1'b0) begin
            errs++; $display("FAIL reset_mid: got=%b out_v=%b req_v=%b instr=%h pc=%h c=%b, required cleared",
                             got, bus.out_valid, bus.req_valid, bus.out_instr, bus.out_pc, bus.out_is_c);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        wait_req(10, got);
        vecs++;
        if (!got || bus.req_addr !== TB_RESET_PC) begin
            errs++; $display("FAIL reset_req: got=%b addr=%h, required %h", got, bus.req_addr, TB_RESET_PC);
        end
        wait_out(50, 100, 100, got);
        vecs++;
        if (!got || bus.out_instr !== 32'h00A00093 || bus.out_pc !== TB_RESET_PC || bus.out_is_c !== 1'b0) begin
            errs++; $display("FAIL reset_out: got=%b instr=%h pc=%h c=%b, required 00a00093 %h 0",
                             got, bus.out_instr, bus.out_pc, bus.out_is_c, TB_RESET_PC);
        end
    endtask

    task automatic test_random_stream;
        bit          got;
        logic [31:0] start;
        logic [31:0] base;
        logic [31:0] mpc;
        logic [31:0] epc;
        logic [31:0] ei;
        logic        ec;
        for (int it = 0; it < 6; it++) begin
            if (it == 5) start = 32'hFFFF_FFF8;
            else start = 32'h0000_A000 + ($urandom_range(0, 255) << 1) + (it * 32'h400);
            base = start & 32'hFFFF_FFFC;
            for (int k = 0; k < 16; k++) mem[base + 32'(k * 4)] = $urandom;
            flush_to(start | 32'($urandom_range(0, 1)), 1'b1);
            mpc = start;
            for (int k = 0; k < 12; k++) begin
                epc = mpc;
                model_next(mpc, ei, ec);
                wait_out(300, 70, 85, got);
                vecs++;
                if (!got || bus.out_instr !== ei || bus.out_pc !== epc || bus.out_is_c !== ec) begin
                    errs++; $display("FAIL stream[%0d.%0d]: got=%b instr=%h pc=%h c=%b, required %h %h %b",
                                     it, k, got, bus.out_instr, bus.out_pc, bus.out_is_c, ei, epc, ec);
                end
            end
            rdy = 1'b1;
        end
    endtask

    initial begin
        mem[32'h0000_0200] = 32'h00A00093;
        mem[32'h0000_0300] = 32'h45854505;
        mem[32'h0000_0400] = 32'h0093_1234;
        mem[32'h0000_0404] = 32'h4501_00A0;
        mem[32'h0000_0600] = 32'h0000_0013;
        bus.out_ready = 1'b0;
        test_reset();
        test_aligned_full();
        test_two_compressed();
        test_straddle();
        test_flush_wait();
        test_backpressure();
        test_freeze();
        test_reset_mid();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_align.md
# instr_align

Fetch-side aligner between the instruction cache and the decompressor. It walks the PC in halfword steps and issues word-aligned 32-bit fetches. It stitches instructions that straddle a word boundary, keeps the spare upper halfword of each fetched word, and emits one raw instruction per handshake. Compressed instructions leave zero-extended to 32 bits, with their PC and an `is_c` flag. Redirects from the back end flush all buffered state.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC used after reset.
- `clk_in` input 1: clock; all state updates on its rising edge.
- `rst_in` input 1: reset, asynchronous and active-high.
- `rdy_in` input 1: global enable; when low, every register holds its value and no handshake completes.
- `req_valid` output 1: fetch request pending.
- `req_addr` output 32: fetch address; bits [1:0] always 0.
- `req_ready` input 1: cache accepts the request this cycle.
- `resp_valid` input 1: fetched word returned; at most one request outstanding.
- `resp_data` input 32: fetched word, little-endian halfwords.
- `out_valid` output 1: instruction available.
- `out_instr` output 32: raw instruction; [31:16]=0 when compressed.
- `out_pc` output 32: PC of `out_instr`.
- `out_is_c` output 1: instruction is 16-bit.
- `out_ready` input 1: consumer takes the instruction.
- `flush_in` input 1: redirect.
- `flush_pc` input 32: target PC; bit 0 ignored, treated as 0.

## Operation
- Registers:
  - `pc`: next instruction address.
  - `hold` [15:0] with `hold_valid`: halfword at address `pc` when `pc[1]`=1.
  - `state` ∈ {IDLE, REQ, WAIT, OUT, DRAIN}.
  - Output registers.
- Full vs compressed: a halfword `h` starts a 32-bit instruction iff `h[1:0]`==2'b11.
- IDLE decides the next action:
  - `pc[1]`=1, `hold_valid`, hold not full → load compressed output from hold; `pc`+=2; clear `hold_valid`; go to OUT.
  - Otherwise → REQ with `req_addr` = {`pc`[31:2],2'b00}. When `pc[1]`=1 and `hold_valid`, the address is `pc`+2 aligned.
- REQ: `req_valid`=1 and stable until `req_ready`, then go to WAIT.
- WAIT, on `resp_valid` with word `w`:
  - **aligned** (`pc[1]`=0), `w[1:0]`≠11: emit {16'b0,`w[15:0]`}, `is_c`=1; `hold`←`w[31:16]`, `hold_valid`←1; `pc`+=2; go to OUT.
  - **aligned**, `w[1:0]`==11: emit `w`; `pc`+=4; `hold_valid`←0; go to OUT.
  - **straddle** (`pc[1]`=1, `hold_valid`): emit {`w[15:0]`,`hold`}, `is_c`=0; `hold`←`w[31:16]`, `hold_valid`←1; `pc`+=4; go to OUT.
  - **refill** (`pc[1]`=1, no hold): `hold`←`w[31:16]`, `hold_valid`←1; go to IDLE; nothing emitted.
- OUT: `out_valid`=1 with stable fields until `out_ready`, then go to IDLE.
- Flush has priority over everything in the same cycle:
  - `pc`←`flush_pc` with bit 0 cleared; `hold_valid`←0; `out_valid`←0; `req_valid`←0.
  - From WAIT → DRAIN; from all other states → IDLE.
- DRAIN:
  - Discard the first `resp_valid`, then go to IDLE.
  - A flush in DRAIN only updates `pc`.
- `rdy_in`=0 freezes all of the above. A flush is honored only when `rdy_in`=1.

## Timing
- Reset values: `pc`=`RESET_PC`, `state`=IDLE, `hold_valid`=0, `req_valid`=0, `out_valid`=0, `req_addr`=0, `out_instr`=0, `out_pc`=0, `out_is_c`=0.
- `req_valid` is registered; it first rises the cycle after IDLE.
- `out_valid` rises the cycle after `resp_valid` is sampled in WAIT, or the cycle after IDLE for a hold-sourced compressed instruction.
- Fastest hold-sourced sequence: IDLE→OUT, i.e. 1 cycle plus the handshake.
- Miss path with zero cache latency, excluding the OUT handshake: IDLE, REQ, WAIT, i.e. 3 cycles per fetched word.
- The request is issued in the cycle after `req_valid` is seen together with `req_ready`.
- `resp_valid` arriving outside WAIT or DRAIN is illegal and ignored.
- `pc` wraps modulo 2^32.

## Structure
- Shared package `fetch_pkg`:
  - state enum `align_state_t`;
  - constant `RVC_FULL = 2'b11`;
  - increment constants `PC_STEP_C = 2` and `PC_STEP_F = 4`.
- No sub-module. The decompressor is instantiated downstream by the parent, not inside this block.

## Test plan
- **Aligned full instruction:** reset, resp `32'h00A00093` → out `32'h00A00093`, pc 0, `is_c`=0; next `req_addr`=4.
- **Two compressed in one word:** resp `32'h45854505` → out `32'h00004505` @pc 0, then from hold `32'h00004585` @pc 2 with no new request between them.
- **Straddle:**
  - flush to 2; resp@0 `32'h0093_xxxx` → refill only, no output;
  - resp@4 `32'hxxxx_00A0` → out `32'h00A00093` @pc 2, `is_c`=0;
  - next pc 6, served from hold.
- **Flush in WAIT:** flush to `0x100` while a request is outstanding → stale resp dropped, next `req_addr`=`0x100`, no spurious `out_valid`.
- **Backpressure and freeze:**
  - hold `out_ready`=0 for 5 cycles → `out_*` stable, no request issued;
  - `rdy_in`=0 mid-REQ → `req_valid`/`req_addr` frozen.
- **Reset mid-operation:** assert `rst_in` in OUT → outputs clear asynchronously; after release the first `req_addr` is `RESET_PC`.
